// File: rtl/sram_pkg.sv
// Shared definitions for the byte-enabled dual-port SRAM.
//   state_e     : clear-sequencer state encoding
//   RDW_OLD/NEW : read-during-write selector values
//   lane_merge  : combine old/new words under per-lane enables
package sram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam int unsigned RDW_OLD = 0;
    localparam int unsigned RDW_NEW = 1;

    // Widest word and lane count lane_merge can handle; callers cast to/from these.
    localparam int unsigned MERGE_W     = 1024;
    localparam int unsigned MERGE_LANES = 64;

    // Lanes with be[k] = 1 take new_word, all others keep old_word.
    function automatic logic [MERGE_W-1:0] lane_merge(
        input logic [MERGE_W-1:0]     old_word,
        input logic [MERGE_W-1:0]     new_word,
        input logic [MERGE_LANES-1:0] be,
        input int unsigned            lane_w
    );
        logic [MERGE_W-1:0]     lane_ones;
        logic [MERGE_W-1:0]     mask;
        logic [MERGE_LANES-1:0] be_sh;
        lane_ones = (MERGE_W'(1) << lane_w) - MERGE_W'(1);
        mask      = '0;
        be_sh     = be;
        for (int unsigned l = 0; l < MERGE_LANES; l++) begin
            if (be_sh[0]) begin
                mask = mask | (lane_ones << (l * lane_w));
            end
            be_sh = be_sh >> 1;
        end
        return (old_word & ~mask) | (new_word & mask);
    endfunction

endpackage

// File: rtl/sram_clr_seq.sv
// Clear sequencer: sweeps every address once after reset or on clr_req.
//   clk, rst_n  : clock, async active-low reset
//   clr_req     : start a sweep (honoured only when idle)
//   busy        : sweep in progress (registered)
//   sweep_we_c  : sweep write strobe to the array
//   sweep_addr  : sweep write address
module sram_clr_seq
    import sram_pkg::*;
#(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned WIDTH_ADDR = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  sweep_we_c,
    output logic [WIDTH_ADDR-1:0] sweep_addr
);

    state_e                state_q, state_d;
    logic [WIDTH_ADDR-1:0] ptr_q, ptr_d;
    logic                  busy_q, busy_d;

    // State, pointer and busy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    // Next state: sweep to DEPTH-1 then idle; clr_req while sweeping is ignored.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                ptr_d = ptr_q + WIDTH_ADDR'(1);
                if (ptr_q == WIDTH_ADDR'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
        busy_d = (state_d == ST_CLEAR);
    end

    assign busy       = busy_q;
    assign sweep_we_c = (state_q == ST_CLEAR);
    assign sweep_addr = ptr_q;

endmodule

// File: rtl/sram_dp_be.sv
// Simple-dual-port SRAM with per-lane write enables, 1- or 2-cycle read
// latency, selectable read-during-write behaviour and a hardware clear sweep.
//   clk, rst_n                     : clock, async active-low reset
//   clr_req / busy                 : start clear sweep / sweep in progress
//   wr_en, wr_addr, wr_data, wr_be : write port with lane enables
//   rd_en, rd_addr                 : read port request
//   rd_data, rd_valid              : read result (held) and one-cycle valid
module sram_dp_be
    import sram_pkg::*;
#(
    parameter int unsigned     WIDTH      = 32,
    parameter int unsigned     DEPTH      = 64,
    parameter int unsigned     WIDTH_ADDR = $clog2(DEPTH),
    parameter int unsigned     LANES      = 4,
    parameter int unsigned     RD_LATENCY = 1,
    parameter int unsigned     RDW_MODE   = RDW_OLD,
    parameter logic [WIDTH-1:0] INIT_VAL  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_req,
    output logic                  busy,
    input  logic                  wr_en,
    input  logic [WIDTH_ADDR-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [LANES-1:0]      wr_be,
    input  logic                  rd_en,
    input  logic [WIDTH_ADDR-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid
);

    localparam int unsigned LANE_W = WIDTH / LANES;

    // Reject illegal configurations at elaboration.
    if (LANES == 0 || (WIDTH % LANES) != 0 || WIDTH > MERGE_W || LANES > MERGE_LANES) begin : g_bad_lanes
        $error("sram_dp_be: WIDTH must be a multiple of LANES (within merge limits)");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("sram_dp_be: RD_LATENCY must be 1 or 2");
    end
    if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_bad_rdw
        $error("sram_dp_be: RDW_MODE must be 0 or 1");
    end

    logic [WIDTH-1:0]      mem [DEPTH];
    logic                  sweep_we_c;
    logic [WIDTH_ADDR-1:0] sweep_addr;

    sram_clr_seq #(
        .DEPTH      (DEPTH),
        .WIDTH_ADDR (WIDTH_ADDR)
    ) u_clr_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_req    (clr_req),
        .busy       (busy),
        .sweep_we_c (sweep_we_c),
        .sweep_addr (sweep_addr)
    );

    logic                  wr_ok_c;
    logic [WIDTH-1:0]      wr_merged_c;
    logic                  mem_we_c;
    logic [WIDTH_ADDR-1:0] mem_addr_c;
    logic [WIDTH-1:0]      mem_wdata_c;

    // Write-port mux: the sweep owns the array while busy.
    always_comb begin
        wr_ok_c     = !busy && wr_en && (32'(wr_addr) < DEPTH);
        wr_merged_c = WIDTH'(lane_merge(MERGE_W'(mem[wr_addr]), MERGE_W'(wr_data),
                                        MERGE_LANES'(wr_be), LANE_W));
        mem_we_c    = 1'b0;
        mem_addr_c  = wr_addr;
        mem_wdata_c = wr_merged_c;
        if (sweep_we_c) begin
            mem_we_c    = 1'b1;
            mem_addr_c  = sweep_addr;
            mem_wdata_c = INIT_VAL;
        end else if (wr_ok_c) begin
            mem_we_c = 1'b1;
        end
    end

    // Storage array: contents are defined by the sweep, so no reset here.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_addr_c] <= mem_wdata_c;
        end
    end

    logic             rd_ok_c;
    logic [WIDTH-1:0] rd_word_c;

    // Read word captured in the issue cycle; out-of-range addresses read as zero.
    always_comb begin
        rd_ok_c   = !busy && rd_en;
        rd_word_c = (32'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;
        if (RDW_MODE == RDW_NEW && wr_ok_c && wr_addr == rd_addr) begin
            rd_word_c = wr_merged_c;
        end
    end

    logic             rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    if (RD_LATENCY == 1) begin : g_lat1
        always_comb begin
            rd_valid_d = rd_ok_c;
            rd_data_d  = rd_ok_c ? rd_word_c : rd_data_q;
        end
    end else begin : g_lat2
        logic             s1_valid_q, s1_valid_d;
        logic [WIDTH-1:0] s1_data_q, s1_data_d;

        // Extra stage between issue and the output register.
        always_comb begin
            s1_valid_d = rd_ok_c;
            s1_data_d  = rd_ok_c ? rd_word_c : s1_data_q;
            rd_valid_d = s1_valid_q;
            rd_data_d  = s1_valid_q ? s1_data_q : rd_data_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_valid_q <= 1'b0;
                s1_data_q  <= '0;
            end else begin
                s1_valid_q <= s1_valid_d;
                s1_data_q  <= s1_data_d;
            end
        end
    end

    // Output register; keeps draining regardless of clear sweeps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_sram_dp_be.sv
// Bench for sram_dp_be: four configurations share one stimulus stream and are
// compared every cycle against an array/queue reference model.
module tb_sram_dp_be;

    localparam int NI = 4;
    localparam logic [31:0] INIT = 32'h5A5A_0F0F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr_req;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rd_en;
    logic [5:0]  rd_addr;

    logic        busy_o     [NI];
    logic        rd_valid_o [NI];
    logic [31:0] rd_data_o  [NI];

    always #5 clk = ~clk;

    // inst0: 64/lat1/old  inst1: 64/lat1/new  inst2: 64/lat2/new  inst3: 48/lat1/old
    sram_dp_be #(.WIDTH(32), .DEPTH(64), .LANES(4), .RD_LATENCY(1), .RDW_MODE(0), .INIT_VAL(INIT)) u_a (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy_o[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o[0]), .rd_valid(rd_valid_o[0]));
    sram_dp_be #(.WIDTH(32), .DEPTH(64), .LANES(4), .RD_LATENCY(1), .RDW_MODE(1), .INIT_VAL(INIT)) u_b (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy_o[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o[1]), .rd_valid(rd_valid_o[1]));
    sram_dp_be #(.WIDTH(32), .DEPTH(64), .LANES(4), .RD_LATENCY(2), .RDW_MODE(1), .INIT_VAL(INIT)) u_c (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy_o[2]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o[2]), .rd_valid(rd_valid_o[2]));
    sram_dp_be #(.WIDTH(32), .DEPTH(48), .LANES(4), .RD_LATENCY(1), .RDW_MODE(0), .INIT_VAL(INIT)) u_d (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy_o[3]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o[3]), .rd_valid(rd_valid_o[3]));

    // ---------------- reference model ----------------
    typedef struct {
        int          inst;
        int          due;
        logic [31:0] data;
    } pend_t;

    logic [31:0] mm [NI][64];
    int          bcnt      [NI];
    logic        exp_busy  [NI];
    logic        exp_valid [NI];
    logic [31:0] exp_data  [NI];
    pend_t       pq [$];
    int          t;
    int          n_pass;
    int          n_total;

    function automatic int dep_of(int i);
        return (i == 3) ? 48 : 64;
    endfunction
    function automatic int lat_of(int i);
        return (i == 2) ? 2 : 1;
    endfunction
    function automatic bit rdw_new(int i);
        return (i == 1 || i == 2);
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] be);
        logic [31:0] mask;
        mask = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) mask = mask | (32'hFF << (8 * k));
        end
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            bcnt[i]      = dep_of(i);
            exp_busy[i]  = 1'b1;
            exp_valid[i] = 1'b0;
            exp_data[i]  = 32'h0;
            for (int a = 0; a < 64; a++) mm[i][a] = INIT;
        end
        pq.delete();
    endtask

    // Apply the inputs present at edge t to every model instance.
    task automatic model_edge();
        pend_t keep [$];
        pend_t p;
        logic [31:0] word;
        for (int i = 0; i < NI; i++) begin
            exp_valid[i] = 1'b0;
            if (bcnt[i] > 0) begin
                bcnt[i]--;
            end else begin
                if (rd_en) begin
                    word = (int'(rd_addr) < dep_of(i)) ? mm[i][rd_addr] : 32'h0;
                    if (rdw_new(i) && wr_en && wr_addr == rd_addr && int'(rd_addr) < dep_of(i))
                        word = merge(word, wr_data, wr_be);
                    p.inst = i;
                    p.due  = t + lat_of(i) - 1;
                    p.data = word;
                    pq.push_back(p);
                end
                if (wr_en && int'(wr_addr) < dep_of(i))
                    mm[i][wr_addr] = merge(mm[i][wr_addr], wr_data, wr_be);
                if (clr_req) begin
                    for (int a = 0; a < 64; a++) mm[i][a] = INIT;
                    bcnt[i] = dep_of(i);
                end
            end
            exp_busy[i] = (bcnt[i] > 0);
        end
        foreach (pq[k]) begin
            if (pq[k].due == t) begin
                exp_valid[pq[k].inst] = 1'b1;
                exp_data[pq[k].inst]  = pq[k].data;
            end else begin
                keep.push_back(pq[k]);
            end
        end
        pq = keep;
    endtask

    task automatic idle_inputs();
        clr_req = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 6'd0;
        wr_data = 32'h0;
        wr_be   = 4'h0;
        rd_en   = 1'b0;
        rd_addr = 6'd0;
    endtask

    // One clock edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        if (rst_n) model_edge();
        @(posedge clk);
        #1;
        t++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int busy_cnt;
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #12;
        for (int i = 0; i < NI; i++) begin
            n_total++;
            if (busy_o[i] !== 1'b1 || rd_valid_o[i] !== 1'b0 || rd_data_o[i] !== 32'h0) begin
                $display("FAIL reset inst%0d: busy/valid/data got %b/%b/%h want 1/0/00000000",
                         i, busy_o[i], rd_valid_o[i], rd_data_o[i]);
            end else n_pass++;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        busy_cnt = 0;
        for (int c = 0; c < 68; c++) begin
            idle_inputs();
            if (c == 10 || c == 64) begin
                rd_en   = 1'b1;
                rd_addr = 6'd5;
            end
            step();
            if (busy_o[0]) busy_cnt++;
            for (int i = 0; i < NI; i++) begin
                n_total++;
                if (busy_o[i] !== exp_busy[i] || rd_valid_o[i] !== exp_valid[i] || rd_data_o[i] !== exp_data[i]) begin
                    $display("FAIL sweep inst%0d cyc%0d: busy/valid/data got %b/%b/%h want %b/%b/%h",
                             i, c, busy_o[i], rd_valid_o[i], rd_data_o[i], exp_busy[i], exp_valid[i], exp_data[i]);
                end else n_pass++;
            end
            if (c == 64) begin
                n_total++;
                if (rd_valid_o[0] !== 1'b1 || rd_data_o[0] !== INIT) begin
                    $display("FAIL first_read: valid/data got %b/%h want 1/%h", rd_valid_o[0], rd_data_o[0], INIT);
                end else n_pass++;
            end
        end
        // busy sampled after edges 0..62 high, low after edge 63
        n_total++;
        if (busy_cnt != 63) begin
            $display("FAIL busy_length: got %0d samples high want 63", busy_cnt);
        end else n_pass++;
    endtask

    task automatic test_lane_writes();
        for (int c = 0; c < 5; c++) begin
            idle_inputs();
            case (c)
                0: begin wr_en = 1'b1; wr_addr = 6'd3; wr_data = 32'hAABBCCDD; wr_be = 4'b1111; end
                1: begin wr_en = 1'b1; wr_addr = 6'd3; wr_data = 32'h11223344; wr_be = 4'b0101; end
                2: begin rd_en = 1'b1; rd_addr = 6'd3; end
                default: ;
            endcase
            step();
            for (int i = 0; i < NI; i++) begin
                n_total++;
                if (busy_o[i] !== exp_busy[i] || rd_valid_o[i] !== exp_valid[i] || rd_data_o[i] !== exp_data[i]) begin
                    $display("FAIL lane_writes inst%0d cyc%0d: busy/valid/data got %b/%b/%h want %b/%b/%h",
                             i, c, busy_o[i], rd_valid_o[i], rd_data_o[i], exp_busy[i], exp_valid[i], exp_data[i]);
                end else n_pass++;
            end
            if (c == 2) begin
                n_total++;
                if (rd_valid_o[0] !== 1'b1 || rd_data_o[0] !== 32'hAA22CC44) begin
                    $display("FAIL lane_merge_value: got %b/%h want 1/aa22cc44", rd_valid_o[0], rd_data_o[0]);
                end else n_pass++;
            end
        end
    endtask

    task automatic test_rdw();
        for (int c = 0; c < 5; c++) begin
            idle_inputs();
            case (c)
                0: begin wr_en = 1'b1; wr_addr = 6'd7; wr_data = 32'h0; wr_be = 4'b1111; end
                1: begin
                    wr_en = 1'b1; wr_addr = 6'd7; wr_data = 32'hFFFFFFFF; wr_be = 4'b0011;
                    rd_en = 1'b1; rd_addr = 6'd7;
                end
                2: begin rd_en = 1'b1; rd_addr = 6'd7; end
                default: ;
            endcase
            step();
            for (int i = 0; i < NI; i++) begin
                n_total++;
                if (busy_o[i] !== exp_busy[i] || rd_valid_o[i] !== exp_valid[i] || rd_data_o[i] !== exp_data[i]) begin
                    $display("FAIL rdw inst%0d cyc%0d: busy/valid/data got %b/%b/%h want %b/%b/%h",
                             i, c, busy_o[i], rd_valid_o[i], rd_data_o[i], exp_busy[i], exp_valid[i], exp_data[i]);
                end else n_pass++;
            end
            if (c == 1) begin
                n_total++;
                if (rd_data_o[0] !== 32'h00000000 || rd_data_o[1] !== 32'h0000FFFF) begin
                    $display("FAIL rdw_same_cycle: old/new got %h/%h want 00000000/0000ffff", rd_data_o[0], rd_data_o[1]);
                end else n_pass++;
            end
            if (c == 2) begin
                n_total++;
                if (rd_data_o[0] !== 32'h0000FFFF || rd_data_o[1] !== 32'h0000FFFF) begin
                    $display("FAIL rdw_followup: old/new got %h/%h want 0000ffff/0000ffff", rd_data_o[0], rd_data_o[1]);
                end else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        int first_pulse;
        pulses      = 0;
        first_pulse = -1;
        for (int c = 0; c < 10; c++) begin
            idle_inputs();
            if (c < 3) begin
                wr_en = 1'b1; wr_addr = 6'(c + 1); wr_data = 32'h1000_0000 * (c + 1) + 32'h55; wr_be = 4'hF;
            end else if (c < 6) begin
                rd_en = 1'b1; rd_addr = 6'(c - 2);
            end
            step();
            if (rd_valid_o[2]) begin
                pulses++;
                if (first_pulse < 0) first_pulse = c;
            end
            for (int i = 0; i < NI; i++) begin
                n_total++;
                if (busy_o[i] !== exp_busy[i] || rd_valid_o[i] !== exp_valid[i] || rd_data_o[i] !== exp_data[i]) begin
                    $display("FAIL back_to_back inst%0d cyc%0d: busy/valid/data got %b/%b/%h want %b/%b/%h",
                             i, c, busy_o[i], rd_valid_o[i], rd_data_o[i], exp_busy[i], exp_valid[i], exp_data[i]);
                end else n_pass++;
            end
        end
        n_total++;
        if (pulses != 3 || first_pulse != 4) begin
            $display("FAIL lat2_pulses: got %0d pulses first at %0d want 3 at 4", pulses, first_pulse);
        end else n_pass++;

        // Two reads in flight, then reset between edges.
        for (int c = 0; c < 2; c++) begin
            idle_inputs();
            rd_en = 1'b1; rd_addr = 6'(c + 1);
            step();
        end
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            if (c > 0) step();
            else #1;
            for (int i = 0; i < NI; i++) begin
                n_total++;
                if (busy_o[i] !== 1'b1 || rd_valid_o[i] !== 1'b0 || rd_data_o[i] !== 32'h0) begin
                    $display("FAIL reset_flush inst%0d cyc%0d: busy/valid/data got %b/%b/%h want 1/0/00000000",
                             i, c, busy_o[i], rd_valid_o[i], rd_data_o[i]);
                end else n_pass++;
            end
        end
        rst_n = 1'b1;
        for (int c = 0; c < 70; c++) begin
            step();
            for (int i = 0; i < NI; i++) begin
                n_total++;
                if (busy_o[i] !== exp_busy[i] || rd_valid_o[i] !== exp_valid[i] || rd_data_o[i] !== exp_data[i]) begin
                    $display("FAIL resweep inst%0d cyc%0d: busy/valid/data got %b/%b/%h want %b/%b/%h",
                             i, c, busy_o[i], rd_valid_o[i], rd_data_o[i], exp_busy[i], exp_valid[i], exp_data[i]);
                end else n_pass++;
            end
        end
    endtask

    task automatic test_clear();
        for (int c = 0; c < 70; c++) begin
            idle_inputs();
            case (c)
                0:  begin wr_en = 1'b1; wr_addr = 6'd9; wr_data = 32'h99999999; wr_be = 4'hF; end
                1:  begin clr_req = 1'b1; wr_en = 1'b1; wr_addr = 6'd10; wr_data = 32'hABABABAB; wr_be = 4'hF; end
                20: clr_req = 1'b1;
                66: begin rd_en = 1'b1; rd_addr = 6'd9; end
                67: begin rd_en = 1'b1; rd_addr = 6'd10; end
                default: ;
            endcase
            step();
            for (int i = 0; i < NI; i++) begin
                n_total++;
                if (busy_o[i] !== exp_busy[i] || rd_valid_o[i] !== exp_valid[i] || rd_data_o[i] !== exp_data[i]) begin
                    $display("FAIL clear inst%0d cyc%0d: busy/valid/data got %b/%b/%h want %b/%b/%h",
                             i, c, busy_o[i], rd_valid_o[i], rd_data_o[i], exp_busy[i], exp_valid[i], exp_data[i]);
                end else n_pass++;
            end
            if (c == 64 || c == 65) begin
                n_total++;
                if (busy_o[0] !== (c == 64)) begin
                    $display("FAIL clear_busy_end cyc%0d: got %b want %b", c, busy_o[0], (c == 64));
                end else n_pass++;
            end
            if (c == 66 || c == 67) begin
                n_total++;
                if (rd_valid_o[0] !== 1'b1 || rd_data_o[0] !== INIT) begin
                    $display("FAIL cleared_word cyc%0d: got %b/%h want 1/%h", c, rd_valid_o[0], rd_data_o[0], INIT);
                end else n_pass++;
            end
        end
    endtask

    task automatic test_out_of_range();
        for (int c = 0; c < 5; c++) begin
            idle_inputs();
            case (c)
                0: begin wr_en = 1'b1; wr_addr = 6'd50; wr_data = 32'h12345678; wr_be = 4'hF; end
                1: begin wr_en = 1'b1; wr_addr = 6'd47; wr_data = 32'hCAFEF00D; wr_be = 4'hF; end
                2: begin rd_en = 1'b1; rd_addr = 6'd50; end
                3: begin rd_en = 1'b1; rd_addr = 6'd47; end
                default: ;
            endcase
            step();
            for (int i = 0; i < NI; i++) begin
                n_total++;
                if (busy_o[i] !== exp_busy[i] || rd_valid_o[i] !== exp_valid[i] || rd_data_o[i] !== exp_data[i]) begin
                    $display("FAIL out_of_range inst%0d cyc%0d: busy/valid/data got %b/%b/%h want %b/%b/%h",
                             i, c, busy_o[i], rd_valid_o[i], rd_data_o[i], exp_busy[i], exp_valid[i], exp_data[i]);
                end else n_pass++;
            end
            if (c == 2) begin
                n_total++;
                if (rd_valid_o[3] !== 1'b1 || rd_data_o[3] !== 32'h0 || rd_data_o[0] !== 32'h12345678) begin
                    $display("FAIL oor_read: d48 %b/%h want 1/00000000, d64 %h want 12345678",
                             rd_valid_o[3], rd_data_o[3], rd_data_o[0]);
                end else n_pass++;
            end
            if (c == 3) begin
                n_total++;
                if (rd_data_o[3] !== 32'hCAFEF00D) begin
                    $display("FAIL last_word: got %h want cafef00d", rd_data_o[3]);
                end else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            idle_inputs();
            clr_req = ($urandom_range(0, 79) == 0);
            wr_en   = $urandom_range(0, 1) == 1;
            wr_addr = 6'($urandom_range(0, 63));
            wr_data = $urandom;
            wr_be   = 4'($urandom_range(0, 15));
            rd_en   = $urandom_range(0, 1) == 1;
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 6'($urandom_range(0, 63));
            step();
            for (int i = 0; i < NI; i++) begin
                n_total++;
                if (busy_o[i] !== exp_busy[i] || rd_valid_o[i] !== exp_valid[i] || rd_data_o[i] !== exp_data[i]) begin
                    $display("FAIL random inst%0d cyc%0d: busy/valid/data got %b/%b/%h want %b/%b/%h",
                             i, c, busy_o[i], rd_valid_o[i], rd_data_o[i], exp_busy[i], exp_valid[i], exp_data[i]);
                end else n_pass++;
            end
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        t       = 0;
        rst_n   = 1'b0;
        idle_inputs();
        test_reset();
        test_lane_writes();
        test_rdw();
        test_back_to_back();
        test_clear();
        test_out_of_range();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
